sha1_round_ctrl: RTL
====================

SHA1_ROUND_CTRL -- requirements
Module: sha1_round_ctrl

Interface
REQ-001 SHALL have parameter STATUS_W, default 8, width of the status bus driven to the LED PIO (legal 4..16).
REQ-002 SHALL have port clk  input  1  system clock; all state changes on the rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to process one 512-bit block; sampled only in IDLE.
REQ-005 SHALL have port first_block  input  1  sampled with an accepted start; 1 means load IV into H0..H4.
REQ-006 SHALL have port abort  input  1  cancels the current block.
REQ-007 SHALL have port w_valid  input  1  message-word source has a 32-bit word ready.
REQ-008 SHALL have port w_ready  output  1  controller accepts a word this cycle.
REQ-009 SHALL have port w_load  output  1  datapath captures the word into W[w_idx]; equals w_valid & w_ready.
REQ-010 SHALL have port w_idx  output  4  index of the word being loaded, 0..15.
REQ-011 SHALL have port iv_load  output  1  datapath loads the SHA-1 IV into H0..H4.
REQ-012 SHALL have port a_init  output  1  datapath copies H0..H4 into A..E.
REQ-013 SHALL have port round_en  output  1  datapath executes one compression round.
REQ-014 SHALL have port round_idx  output  7  current round t, 0..79.
REQ-015 SHALL have port f_sel  output  2  0 = Ch, 1 = Parity, 2 = Maj, 3 = Parity.
REQ-016 SHALL have port k_sel  output  2  selects K0..K3.
REQ-017 SHALL have port sched_en  output  1  message-schedule expansion active (t >= 16).
REQ-018 SHALL have port h_update  output  1  datapath adds A..E into H0..H4.
REQ-019 SHALL have port busy  output  1  high in every state except IDLE.
REQ-020 SHALL have port done  output  1  one-cycle pulse when a block completes.
REQ-021 SHALL have port status  output  STATUS_W  LED status word.

Function
REQ-022 SHALL implement the FSM states IDLE, INIT, LOAD, ROUND, UPDATE and DONE.
REQ-023 SHALL move IDLE -> INIT when start=1 and abort=0; start in any other state SHALL be ignored.
REQ-024 In INIT (exactly one cycle), SHALL assert a_init=1 and iv_load=first_block (as latched at start), then go to LOAD.
REQ-025 In LOAD, SHALL drive w_ready=1 and w_idx = the count of words accepted so far, and SHALL increment the count only on w_valid=1; w_valid=0 stalls the FSM indefinitely.
REQ-026 SHALL go to ROUND on the cycle after the 16th accepted word.
REQ-027 In ROUND, SHALL assert round_en=1 for exactly 80 consecutive cycles with round_idx = 0..79.
REQ-028 SHALL set f_sel = k_sel = 0/1/2/3 for t in 0-19/20-39/40-59/60-79 respectively, and sched_en = (t >= 16).
REQ-029 After round 79, SHALL go to UPDATE, assert h_update=1 for one cycle, then go to DONE.
REQ-030 In DONE, SHALL assert done=1 for one cycle, then go to IDLE.
REQ-031 SHALL drive w_ready, w_load, round_en, a_init, iv_load, h_update and done to 0 outside their stated states; round_idx and w_idx SHALL hold 0 outside ROUND and LOAD respectively.
REQ-032 With start at cycle 0 and no stalls, SHALL produce INIT at cycle 1, LOAD at cycles 2-17, ROUND at cycles 18-97, UPDATE at cycle 98, done at cycle 99, and IDLE at cycle 100.
REQ-033 On abort=1 in any non-IDLE state, SHALL enter IDLE at the next edge with no h_update and no done; abort SHALL take priority over every other transition, including the final LOAD word and round 79.
REQ-034 In IDLE with start=1 and abort=1 together, SHALL remain in IDLE.
REQ-035 SHALL drive status[0]=busy.
REQ-036 SHALL drive status[1]=done_sticky: set on done, cleared on an accepted start.
REQ-037 SHALL drive status[2]=abort_sticky: set on an abort taken in a non-IDLE state, cleared on an accepted start.
REQ-038 SHALL drive status[STATUS_W-1:3] as a count of completed blocks, incremented on done and wrapping modulo 2^(STATUS_W-3).

Reset
REQ-039 While reset=1, the FSM SHALL be in IDLE, all outputs SHALL be 0, and the word counter, round counter, latched first_block, sticky bits and block count SHALL be 0.
REQ-040 Reset asserted mid-block SHALL abandon the block with no done and no h_update.
REQ-041 After reset deasserts, the first start SHALL be accepted on the first rising edge at which it is high.

Verification
REQ-042 Nominal: start=1 with first_block=1 and w_valid held high -> iv_load and a_init at cycle 1, 16 w_load pulses with w_idx 0..15, round_en for 80 cycles, h_update at cycle 98, done at cycle 99, status=8'b0000_1010 after done.
REQ-043 Stall: w_valid low for 5 cycles after word 7 -> w_idx holds at 7, done at cycle 104, round boundaries t=20/40/60 change f_sel and k_sel to 1/2/3.
REQ-044 Abort: abort at round 79 -> no h_update, no done, IDLE next cycle, status[2]=1, block count unchanged.
REQ-045 Collisions: start during ROUND is ignored; start and abort together in IDLE leave the FSM in IDLE with busy=0.
REQ-046 Reset mid-LOAD at word 9 -> all outputs 0 immediately (asynchronous); a subsequent start runs a full block with w_idx restarting at 0.
REQ-047 Wrap: 32 consecutive blocks with STATUS_W=8 -> block count wraps 31 -> 0.

Source files
------------

// File: rtl/sha1_round_ctrl.sv
// SHA-1 block controller: sequences IV/state init, 16 message-word loads,
// 80 compression rounds and the final H update. It drives the datapath
// strobes and an LED status word.
module sha1_round_ctrl #(
    parameter int STATUS_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                first_block,
    input  logic                abort,
    input  logic                w_valid,
    output logic                w_ready,
    output logic                w_load,
    output logic [3:0]          w_idx,
    output logic                iv_load,
    output logic                a_init,
    output logic                round_en,
    output logic [6:0]          round_idx,
    output logic [1:0]          f_sel,
    output logic [1:0]          k_sel,
    output logic                sched_en,
    output logic                h_update,
    output logic                busy,
    output logic                done,
    output logic [STATUS_W-1:0] status
);

    localparam int CW = STATUS_W - 3;

    typedef enum logic [2:0] {IDLE, INIT, LOAD, ROUND, UPDATE, DONE} state_t;

    state_t        state;
    logic          fb_lat;
    logic          done_sticky;
    logic          abort_sticky;
    logic [CW-1:0] blk_cnt;
    logic [6:0]    rnd_nxt;

    // Round-function / constant group for round t: four groups of 20 rounds.
    function automatic logic [1:0] phase_of(input logic [6:0] t);
        if (t >= 7'd60)      return 2'd3;
        else if (t >= 7'd40) return 2'd2;
        else if (t >= 7'd20) return 2'd1;
        else                 return 2'd0;
    endfunction

    assign rnd_nxt = round_idx + 7'd1;

    // w_load must follow w_valid in the same cycle, so it stays combinational.
    assign w_load  = w_valid & w_ready;
    // iv_load rides on the INIT strobe, gated by first_block as captured at start.
    assign iv_load = a_init & fb_lat;
    assign status  = {blk_cnt, abort_sticky, done_sticky, busy};

    // Controller FSM. Every strobe is registered and is set on the edge that
    // enters its state, so the outputs line up with the state cycle-for-cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            fb_lat       <= 1'b0;
            done_sticky  <= 1'b0;
            abort_sticky <= 1'b0;
            blk_cnt      <= '0;
            w_ready      <= 1'b0;
            w_idx        <= 4'd0;
            a_init       <= 1'b0;
            round_en     <= 1'b0;
            round_idx    <= 7'd0;
            f_sel        <= 2'd0;
            k_sel        <= 2'd0;
            sched_en     <= 1'b0;
            h_update     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            // The single-cycle strobes default low.
            a_init   <= 1'b0;
            h_update <= 1'b0;
            done     <= 1'b0;
            if (state != IDLE && abort) begin
                // Abort beats every other transition, including the last word and round 79.
                state        <= IDLE;
                busy         <= 1'b0;
                w_ready      <= 1'b0;
                w_idx        <= 4'd0;
                round_en     <= 1'b0;
                round_idx    <= 7'd0;
                f_sel        <= 2'd0;
                k_sel        <= 2'd0;
                sched_en     <= 1'b0;
                abort_sticky <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state        <= INIT;
                            busy         <= 1'b1;
                            fb_lat       <= first_block;
                            a_init       <= 1'b1;
                            done_sticky  <= 1'b0;
                            abort_sticky <= 1'b0;
                        end
                    end
                    INIT: begin
                        state   <= LOAD;
                        w_ready <= 1'b1;
                        w_idx   <= 4'd0;
                    end
                    LOAD: begin
                        if (w_valid) begin
                            if (w_idx == 4'd15) begin
                                state     <= ROUND;
                                w_ready   <= 1'b0;
                                w_idx     <= 4'd0;
                                round_en  <= 1'b1;
                                round_idx <= 7'd0;
                                f_sel     <= 2'd0;
                                k_sel     <= 2'd0;
                                sched_en  <= 1'b0;
                            end else begin
                                w_idx <= w_idx + 4'd1;
                            end
                        end
                    end
                    ROUND: begin
                        if (round_idx == 7'd79) begin
                            state     <= UPDATE;
                            round_en  <= 1'b0;
                            round_idx <= 7'd0;
                            f_sel     <= 2'd0;
                            k_sel     <= 2'd0;
                            sched_en  <= 1'b0;
                            h_update  <= 1'b1;
                        end else begin
                            round_idx <= rnd_nxt;
                            f_sel     <= phase_of(rnd_nxt);
                            k_sel     <= phase_of(rnd_nxt);
                            sched_en  <= (rnd_nxt >= 7'd16);
                        end
                    end
                    UPDATE: begin
                        state       <= DONE;
                        done        <= 1'b1;
                        done_sticky <= 1'b1;
                        blk_cnt     <= blk_cnt + CW'(1);
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
